// File: rtl/rgb_to_bayer_mosaic_pkg.sv
// Shared Bayer CFA definitions: pixel type and pattern encodings plus the
// helper that maps a CFA pattern and a pixel's row/column parity to its type.
// Latency: n/a (types and a pure function). Backpressure: n/a.
package bayer_pkg;

  // Same encoding the demosaic uses for its center pixel type.
  typedef enum logic [1:0] {
    BLUE           = 2'd0,
    GREEN_BLUE_ROW = 2'd1,
    GREEN_RED_ROW  = 2'd2,
    RED            = 2'd3
  } pixel_type_t;

  typedef enum logic [1:0] {
    BGGR = 2'd0,
    GBRG = 2'd1,
    GRBG = 2'd2,
    RGGB = 2'd3
  } bayer_pattern_t;

  // Payload through the output skid buffer: {raw[7:0], type[1:0], sof, eol}.
  localparam int PAYLOAD_W = 12;

  // The pattern code is the type of the (even row, even col) pixel, so XOR
  // with the parity bits walks the 2x2 tile.
  function automatic pixel_type_t pixel_type(input bayer_pattern_t pattern,
                                             input logic row_lsb,
                                             input logic col_lsb);
    return pixel_type_t'({row_lsb, col_lsb} ^ pattern);
  endfunction

endpackage

// File: rtl/rgb_to_bayer_mosaic_if.sv
// Stream bundle for the mosaic: RGB pixel input side (s_*) and Bayer raw
// output side (m_*). slave = the mosaic block, master = the source/sink.
// Latency/backpressure: defined by the block attached to the slave modport.
interface rgb_to_bayer_mosaic_if;
  import bayer_pkg::*;

  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_rgb;
  logic        s_sof;
  logic        s_eol;

  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_raw;
  pixel_type_t m_pixel_type;
  logic        m_sof;
  logic        m_eol;

  modport slave (
    input  s_valid, s_rgb, s_sof, s_eol, m_ready,
    output s_ready, m_valid, m_raw, m_pixel_type, m_sof, m_eol
  );

  modport master (
    output s_valid, s_rgb, s_sof, s_eol, m_ready,
    input  s_ready, m_valid, m_raw, m_pixel_type, m_sof, m_eol
  );

endinterface

// File: rtl/rgb_to_bayer_mosaic_skid.sv
// stream_skid_buffer: 2-entry valid/ready register stage (main + skid).
// Latency: 1 cycle accept-to-valid; full 1/clk throughput when draining.
// Backpressure: in_rdy_o is registered (= skid empty); out data held while stalled.
// Ports: clk, reset_n; in_vld_i/in_rdy_o/in_dat_i; out_vld_o/out_rdy_i/out_dat_o.
module stream_skid_buffer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_dat_i,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic [W-1:0] out_dat_o
);

  logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q;
  logic [W-1:0] main_dat_q, main_dat_d, skid_dat_q, skid_dat_d;
  logic         in_fire;

  assign in_fire = in_vld_i && rdy_q;

  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (!main_vld_q || out_rdy_i) begin
      // Main is free this cycle. in_fire implies skid empty, so a full skid
      // and a new input never arrive together.
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_dat_d = skid_dat_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = in_fire;
        if (in_fire) main_dat_d = in_dat_i;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
      skid_dat_d = in_dat_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_dat_q <= '0;
      skid_dat_q <= '0;
      rdy_q      <= 1'b1;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_dat_q <= main_dat_d;
      skid_dat_q <= skid_dat_d;
      rdy_q      <= !skid_vld_d;
    end
  end

  assign in_rdy_o  = rdy_q;
  assign out_vld_o = main_vld_q;
  assign out_dat_o = main_dat_q;

endmodule

// File: rtl/rgb_to_bayer_mosaic.sv
// rgb_to_bayer_mosaic: raster RGB888 stream -> 8-bit Bayer raw + CFA pixel type.
// Latency: 1 cycle accept-to-valid. Backpressure: 2-entry skid, full rate.
// Ports: clk, reset_n, bayer_pattern (sampled on sof), bus (slave stream),
// err_line_length / err_frame_height (sticky, cleared by the next sof).
module rgb_to_bayer_mosaic
  import bayer_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [1:0]                  bayer_pattern,
  rgb_to_bayer_mosaic_if.slave        bus,
  output logic                        err_line_length,
  output logic                        err_frame_height
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(HEIGHT);

  logic [CW-1:0]  col_q, col_d, col_eff;
  logic [RW-1:0]  row_q, row_d, row_base;
  bayer_pattern_t pattern_q, pattern_d, pat_eff;
  logic           sof_seen_q, sof_seen_d;
  logic           err_line_q, err_line_d, err_frame_q, err_frame_d;

  logic           acc, in_rdy, row_wrap, row_lsb, at_last, line_err, frame_err;
  pixel_type_t    ptype;
  logic [7:0]     raw;
  logic [PAYLOAD_W-1:0] in_dat, out_dat;

  assign acc      = bus.s_valid && in_rdy;
  // An accepted sof is position (0,0) and uses the incoming pattern at once.
  assign pat_eff  = bus.s_sof ? bayer_pattern_t'(bayer_pattern) : pattern_q;
  assign row_wrap = (row_q == ROW_END);
  assign col_eff  = bus.s_sof ? '0 : col_q;
  assign row_base = bus.s_sof ? '0 : row_q;
  // Pixels past the last line (no sof yet) are emitted with row parity 0.
  assign row_lsb  = !(bus.s_sof || row_wrap) && row_q[0];
  assign ptype    = pixel_type(pat_eff, row_lsb, col_eff[0]);
  assign at_last  = (col_eff == COL_LAST);
  // eol without the last column, or the last column without eol.
  assign line_err  = bus.s_eol ^ at_last;
  assign frame_err = bus.s_sof ? (sof_seen_q && !row_wrap) : row_wrap;

  always_comb begin
    case (ptype)
      RED:     raw = bus.s_rgb[23:16];
      BLUE:    raw = bus.s_rgb[7:0];
      default: raw = bus.s_rgb[15:8];
    endcase
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    pattern_d   = pattern_q;
    sof_seen_d  = sof_seen_q;
    err_line_d  = err_line_q;
    err_frame_d = err_frame_q;
    if (acc) begin
      pattern_d  = pat_eff;
      sof_seen_d = sof_seen_q || bus.s_sof;
      if (bus.s_eol || at_last) begin
        col_d = '0;
        row_d = (row_base == ROW_END) ? row_base : row_base + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_base;
      end
      // sof clears the flags, but an error seen on the sof pixel itself wins.
      err_line_d  = (!bus.s_sof && err_line_q)  || line_err;
      err_frame_d = (!bus.s_sof && err_frame_q) || frame_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q       <= '0;
      row_q       <= '0;
      pattern_q   <= BGGR;
      sof_seen_q  <= 1'b0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      pattern_q   <= pattern_d;
      sof_seen_q  <= sof_seen_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
    end
  end

  assign in_dat = {raw, ptype, bus.s_sof, bus.s_eol};

  stream_skid_buffer #(.W(PAYLOAD_W)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_vld_i  (bus.s_valid),
    .in_rdy_o  (in_rdy),
    .in_dat_i  (in_dat),
    .out_vld_o (bus.m_valid),
    .out_rdy_i (bus.m_ready),
    .out_dat_o (out_dat)
  );

  assign bus.s_ready      = in_rdy;
  assign bus.m_raw        = out_dat[11:4];
  assign bus.m_pixel_type = pixel_type_t'(out_dat[3:2]);
  assign bus.m_sof        = out_dat[1];
  assign bus.m_eol        = out_dat[0];
  assign err_line_length  = err_line_q;
  assign err_frame_height = err_frame_q;

endmodule

// File: tb/tb_rgb_to_bayer_mosaic.sv
// Directed bench for rgb_to_bayer_mosaic on a 4x2 frame.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Every scenario task checks its own expectations inline.
module tb_rgb_to_bayer_mosaic;

  localparam int W = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] bayer_pattern;
  logic       err_line_length, err_frame_height;
  int         tests = 0;
  int         fails = 0;

  rgb_to_bayer_mosaic_if bus();

  rgb_to_bayer_mosaic #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bayer_pattern    (bayer_pattern),
    .bus              (bus),
    .err_line_length  (err_line_length),
    .err_frame_height (err_frame_height)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [23:0] rgb, input logic sof, input logic eol);
    bus.s_valid = v;
    bus.s_rgb   = rgb;
    bus.s_sof   = sof;
    bus.s_eol   = eol;
  endtask

  function automatic logic [23:0] pix(input int k);
    return {8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k)};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    bus.m_ready   = 1'b1;
    bayer_pattern = 2'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    tests++;
    if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); end
    tests++;
    if ({bus.m_raw, bus.m_pixel_type, bus.m_sof, bus.m_eol} !== 12'h000) begin
      fails++; $display("FAIL reset_m_data: got %h want 000", {bus.m_raw, bus.m_pixel_type, bus.m_sof, bus.m_eol});
    end
    tests++;
    if ({err_line_length, err_frame_height} !== 2'b00) begin
      fails++; $display("FAIL reset_errs: got %b want 00", {err_line_length, err_frame_height});
    end
  endtask

  // One full 4x2 frame of rgb 302010 at m_ready=1; each pixel's output must
  // appear exactly one cycle after its accept, back to back.
  task automatic run_frame(input logic [1:0] pat, input logic change_mid,
                           input logic [63:0] exp_raw, input logic [15:0] exp_type);
    logic [12:0] got, exp;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        exp = {1'b1, exp_raw[63-8*(i-1) -: 8], exp_type[15-2*(i-1) -: 2],
               (i - 1) == 0, ((i - 1) % 4) == 3};
        got = {bus.m_valid, bus.m_raw, bus.m_pixel_type, bus.m_sof, bus.m_eol};
        tests++;
        if (got !== exp) begin
          fails++; $display("FAIL frame_pat%0d_px%0d: got %h want %h", pat, i - 1, got, exp);
        end
      end
      if (i < 8) begin
        if (i == 0) bayer_pattern = pat;
        if (change_mid && i == 2) bayer_pattern = 2'd0;
        drive(1'b1, 24'h302010, i == 0, (i % 4) == 3);
      end else begin
        drive(1'b0, 24'h0, 1'b0, 1'b0);
      end
      @(negedge clk);
    end
    tests++;
    if ({err_line_length, err_frame_height} !== 2'b00) begin
      fails++; $display("FAIL frame_pat%0d_errs: got %b want 00", pat, {err_line_length, err_frame_height});
    end
  endtask

  task automatic test_bggr_frame();
    run_frame(2'd0, 1'b0, 64'h10201020_20302030, 16'b00_01_00_01_10_11_10_11);
  endtask

  task automatic test_pattern_change();
    run_frame(2'd3, 1'b1, 64'h30203020_20102010, 16'b11_10_11_10_01_00_01_00);
    // The pattern written mid-frame (BGGR) is picked up by the next sof.
    drive(1'b1, 24'h302010, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if ({bus.m_valid, bus.m_raw, bus.m_pixel_type, bus.m_sof} !== {1'b1, 8'h10, 2'd0, 1'b1}) begin
      fail_line("pattern_next_sof", {bus.m_valid, bus.m_raw, bus.m_pixel_type, bus.m_sof}, {1'b1, 8'h10, 2'd0, 1'b1});
    end
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  function automatic void fail_line(input string name, input logic [11:0] got, input logic [11:0] exp);
    fails++;
    $display("FAIL %s: got %h want %h", name, got, exp);
  endfunction

  task automatic test_stall();
    logic [31:0] exp_tab;
    int acc, out_idx;
    logic rdy;
    exp_tab = 32'h10211223;
    acc = 0;
    out_idx = 0;
    bus.m_ready = 1'b0;
    bayer_pattern = 2'd0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, pix(acc), acc == 0, acc == 3);
      rdy = bus.s_ready;
      @(posedge clk);
      if (rdy) acc++;
      @(negedge clk);
      tests++;
      if (bus.m_valid !== 1'b1 || bus.m_raw !== 8'h10) begin
        fails++; $display("FAIL stall_hold_c%0d: got v=%b raw=%h want v=1 raw=10", c, bus.m_valid, bus.m_raw);
      end
    end
    tests++;
    if (acc != 2) begin fails++; $display("FAIL stall_accepts: got %0d want 2", acc); end
    tests++;
    if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL stall_s_ready: got %b want 0", bus.s_ready); end
    bus.m_ready = 1'b1;
    for (int c = 0; c < 12 && out_idx < 4; c++) begin
      if (bus.m_valid === 1'b1) begin
        tests++;
        if (bus.m_raw !== exp_tab[31-8*out_idx -: 8]) begin
          fails++; $display("FAIL stall_order_%0d: got %h want %h", out_idx, bus.m_raw, exp_tab[31-8*out_idx -: 8]);
        end
        out_idx++;
      end
      if (acc < 4) drive(1'b1, pix(acc), acc == 0, acc == 3);
      else         drive(1'b0, 24'h0, 1'b0, 1'b0);
      rdy = bus.s_ready;
      @(posedge clk);
      if (rdy && acc < 4) acc++;
      @(negedge clk);
    end
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    tests++;
    if (out_idx != 4) begin fails++; $display("FAIL stall_drain: got %0d outputs want 4", out_idx); end
  endtask

  task automatic test_line_length();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 24'hAABBCC, i == 0, i == 2);
      @(negedge clk);
      if (i == 1) begin
        tests++;
        if (err_line_length !== 1'b0) begin fails++; $display("FAIL line_err_early: got %b want 0", err_line_length); end
      end
    end
    tests++;
    if (err_line_length !== 1'b1) begin fails++; $display("FAIL line_err_set: got %b want 1", err_line_length); end
    // Short line ended: next pixel is row 1, col 0 -> green in red row.
    drive(1'b1, 24'hAABBCC, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if ({bus.m_pixel_type, bus.m_raw} !== {2'd2, 8'hBB}) begin
      fails++; $display("FAIL line_next_px: got %h want %h", {bus.m_pixel_type, bus.m_raw}, {2'd2, 8'hBB});
    end
    tests++;
    if (err_line_length !== 1'b1) begin fails++; $display("FAIL line_err_sticky: got %b want 1", err_line_length); end
    drive(1'b1, 24'hAABBCC, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (err_line_length !== 1'b0) begin fails++; $display("FAIL line_err_clear: got %b want 0", err_line_length); end
    tests++;
    if ({bus.m_sof, bus.m_pixel_type, bus.m_raw} !== {1'b1, 2'd0, 8'hCC}) begin
      fails++; $display("FAIL line_sof_px: got %h want %h", {bus.m_sof, bus.m_pixel_type, bus.m_raw}, {1'b1, 2'd0, 8'hCC});
    end
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_frame_height();
    do_reset();
    bayer_pattern = 2'd3;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 24'h112233, i == 0, i == 3);
      @(negedge clk);
    end
    tests++;
    if ({err_line_length, err_frame_height} !== 2'b00) begin
      fails++; $display("FAIL height_first_line: got %b want 00", {err_line_length, err_frame_height});
    end
    drive(1'b1, 24'h112233, 1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if (err_frame_height !== 1'b1) begin fails++; $display("FAIL height_err_set: got %b want 1", err_frame_height); end
    tests++;
    if ({bus.m_sof, bus.m_pixel_type, bus.m_raw} !== {1'b1, 2'd3, 8'h11}) begin
      fails++; $display("FAIL height_sof_px: got %h want %h", {bus.m_sof, bus.m_pixel_type, bus.m_raw}, {1'b1, 2'd3, 8'h11});
    end
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (err_frame_height !== 1'b1) begin fails++; $display("FAIL height_err_sticky: got %b want 1", err_frame_height); end
  endtask

  task automatic test_reset_while_full();
    bus.m_ready = 1'b0;
    bayer_pattern = 2'd0;
    drive(1'b1, 24'h302010, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 24'h302010, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    tests++;
    if ({bus.m_valid, bus.s_ready} !== 2'b10) begin
      fails++; $display("FAIL rstfull_pre: got v/rdy=%b want 10", {bus.m_valid, bus.s_ready});
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({bus.m_valid, bus.s_ready} !== 2'b01) begin
      fails++; $display("FAIL rstfull_async: got v/rdy=%b want 01", {bus.m_valid, bus.s_ready});
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.m_ready = 1'b1;
    bayer_pattern = 2'd3;   // must be ignored: no sof on this pixel
    drive(1'b1, 24'h302010, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    tests++;
    if ({bus.m_valid, bus.m_sof, bus.m_pixel_type, bus.m_raw} !== {1'b1, 1'b0, 2'd0, 8'h10}) begin
      fails++; $display("FAIL rstfull_first_px: got %h want %h",
                        {bus.m_valid, bus.m_sof, bus.m_pixel_type, bus.m_raw}, {1'b1, 1'b0, 2'd0, 8'h10});
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.m_ready   = 1'b1;
    bayer_pattern = 2'd0;
    drive(1'b0, 24'h0, 1'b0, 1'b0);
    test_reset();
    test_bggr_frame();
    test_pattern_change();
    test_stall();
    test_line_length();
    test_frame_height();
    test_reset_while_full();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rgb_to_bayer_mosaic.md
Name: rgb_to_bayer_mosaic

Overview:
- Re-mosaics a raster-ordered 24-bit RGB pixel stream into an 8-bit Bayer raw stream. Each output sample carries its 2-bit CFA pixel type, using the same encoding the demosaic consumes.
- Used to synthesize sensor-like test frames from RGB sources, and for loopback verification of the demosaic path.
- Valid/ready streaming on both sides. One-cycle latency. Full throughput under backpressure.

Parameters:
- WIDTH, 640, active pixels per line (≥2, even).
- HEIGHT, 480, active lines per frame (≥2, even).

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- bayer_pattern  in  2  CFA order: 0 BGGR, 1 GBRG, 2 GRBG, 3 RGGB. Sampled on the accepted sof pixel.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input may be accepted.
- s_rgb  in  24  [23:16] red, [15:8] green, [7:0] blue.
- s_sof  in  1  first pixel of frame.
- s_eol  in  1  last pixel of line.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts.
- m_raw  out  8  selected channel value.
- m_pixel_type  out  2  0 blue, 1 green in blue row, 2 green in red row, 3 red.
- m_sof  out  1  forwarded sof.
- m_eol  out  1  forwarded eol.
- err_line_length  out  1  sticky line-length error.
- err_frame_height  out  1  sticky frame-height error.

Behaviour:
- Reset (async assert, sync release): m_valid=0; s_ready=1; m_raw, m_pixel_type, m_sof, m_eol = 0; both err flags = 0; col=0; row=0; pattern register=0 (BGGR). Any in-flight data is discarded.
- Transfer occurs on a rising edge with valid&&ready. Nothing else advances state.
- Position counters: col, $clog2(WIDTH) bits; row, $clog2(HEIGHT+1) bits.
  - An accepted s_sof pixel is treated as (row 0, col 0) regardless of the counters. The pattern register loads bayer_pattern, and that same pixel already uses the new value (bypass).
- Pixel type = {row[0], col[0]} XOR pattern.
  - Channel mux: type 3 → red; types 1 and 2 → green; type 0 → blue.
  - No arithmetic and no rounding; m_raw is the raw channel byte.
- Counter advance on an accepted pixel:
  - If s_eol, or col==WIDTH-1: col←0, row←row+1.
  - Otherwise col←col+1.
  - Row saturates at HEIGHT.
- err_line_length sets when either occurs:
  - s_eol is accepted with col≠WIDTH-1;
  - col==WIDTH-1 is accepted without s_eol. This is an auto line wrap; the output m_eol is still the forwarded input flag, never synthesized.
- err_frame_height sets when either occurs:
  - s_sof is accepted while row≠HEIGHT. The very first sof after reset is exempt.
  - A pixel is accepted while row==HEIGHT without s_sof. That pixel is emitted using row parity 0.
- Both err flags clear on the accepted s_sof pixel. Errors detected on that same pixel take precedence over the clear, so the flag reads 1 in the following cycle.
- Output stage is a 2-entry skid buffer: one main output register plus one skid register.
  - Latency is 1 cycle from input accept to m_valid.
  - s_ready = !skid_full, registered.
  - With m_ready held low: the first pixel fills main, the second fills skid, then s_ready drops.
  - When m_ready rises: skid moves to main and s_ready returns the next cycle.
  - Output ordering is never violated.
  - m_* outputs are held stable while m_valid && !m_ready.
- Simultaneous input accept and output drain in the same cycle sustains 1 pixel/clk.
- bayer_pattern changes mid-frame are ignored until the next accepted sof.

Decomposition:
- Shared package bayer_pkg holds:
  - typedef pixel_type_t, 2-bit enum: BLUE=0, GREEN_BLUE_ROW=1, GREEN_RED_ROW=2, RED=3;
  - typedef bayer_pattern_t: BGGR=0, GBRG=1, GRBG=2, RGGB=3;
  - function pixel_type(pattern, row_lsb, col_lsb).
- The demosaic may adopt the same package for its center_pixel_type encoding.
- One sub-module: stream_skid_buffer, parameterized payload width (here 12 bits: raw, type, sof, eol).

Test Plan:
- 4×2 frame (WIDTH=4, HEIGHT=2), BGGR, every pixel rgb=0x30_20_10, m_ready=1 → raw 10,20,10,20 / 20,30,20,30; types 0,1,0,1 / 2,3,2,3; 8 outputs in 8 consecutive cycles starting 1 cycle after the first accept; no errors.
- Same frame with bayer_pattern=3 (RGGB) applied at sof, then changed to 0 mid-frame → types 3,2,3,2 / 1,0,1,0 for the whole frame; the change takes effect only at the next sof.
- m_ready low for 5 cycles while s_valid is held → exactly 2 accepts, then s_ready=0; after release, output order is preserved and the stalled m_raw stays stable throughout.
- s_eol at col 2 on a WIDTH=4 line → err_line_length=1 on the next cycle; the next pixel is emitted with row parity 1 and col 0; the flag clears after the next accepted sof.
- sof after only 1 line of a HEIGHT=2 frame → err_frame_height=1; that sof pixel is emitted as type per (0,0).
- reset_n low for 1 cycle while both the main and skid registers are full → m_valid=0 immediately (asynchronous) and s_ready=1; the next pixel accepted without sof is emitted as (0,0) BGGR, type 0.
